// File: rtl/dmb_crc_pkg.sv
// Shared CRC-32 definitions for the DMB link generator and frame checker.
// Both ends import this package so the step equations exist in one place only.
package dmb_crc_pkg;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  // Reflected form of polynomial 0x04C11DB7
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_CRC_ERR = 2'd1;
  localparam logic [1:0] ST_SHORT   = 2'd2;
  localparam logic [1:0] ST_LONG    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DROP    = 2'd2
  } chk_state_t;

  // Bit 0 of the word is the first bit on the wire, so it enters the register first.
  function automatic logic [31:0] crc32_d16_step(input logic [31:0] crc, input logic [15:0] d);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 16; i++) begin
      fb = c[0] ^ d[i];
      c  = {1'b0, c[31:1]};
      if (fb) begin
        c = c ^ CRC_POLY_REFL;
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] bitrev16(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = x[15-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32 checker for framed 16-bit words whose last two words are the CRC.
// Because the frame length is only known at eof, the two newest words sit in a delay
// line and are kept out of the CRC until they are known to be payload.
module crc32_frame_checker
  import dmb_crc_pkg::*;
#(
  parameter int MAX_WORDS = 4096,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      d,
  input  logic             d_valid,
  input  logic             sof,
  input  logic             eof,
  output logic             done,
  output logic             good,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int WC_W = $clog2(MAX_WORDS + 1);

  chk_state_t        r_state;
  chk_state_t        w_next_state;
  logic [31:0]       r_crc;
  logic [15:0]       r_d1;
  logic [15:0]       r_d2;
  logic [1:0]        r_fill;
  logic [WC_W-1:0]   r_wcnt;
  logic              r_done;
  logic              r_good;
  logic [1:0]        r_status;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [CNT_W-1:0]  r_err_cnt;

  logic [WC_W-1:0]   w_wcnt_inc;
  logic [31:0]       w_crc_step;
  logic              w_crc_ok;
  logic              w_start;
  logic              w_shift;
  logic              w_report;
  logic              w_rep_good;
  logic [1:0]        w_rep_status;

  assign w_wcnt_inc = r_wcnt + WC_W'(1);
  assign w_crc_step = crc32_d16_step(r_crc, r_d2);
  assign w_crc_ok   = (r_d1 == ~bitrev16(w_crc_step[31:16])) &&
                      (d    == ~bitrev16(w_crc_step[15:0]));

  // A valid sof always (re)starts a frame; other valid words only matter inside PAYLOAD.
  assign w_start = d_valid && sof;
  assign w_shift = d_valid && !sof && (r_state == S_PAYLOAD);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; a sof that also carries eof is a complete one-word frame, so it ends in IDLE
  always_comb begin
    w_next_state = r_state;
    if (d_valid) begin
      case (r_state)
        S_IDLE: begin
          if (sof && !eof) w_next_state = S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (sof)                                  w_next_state = eof ? S_IDLE : S_PAYLOAD;
          else if (eof)                             w_next_state = S_IDLE;
          else if (w_wcnt_inc == WC_W'(MAX_WORDS))  w_next_state = S_DROP;
        end
        S_DROP: begin
          if (sof)      w_next_state = eof ? S_IDLE : S_PAYLOAD;
          else if (eof) w_next_state = S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Frame verdict; a sof+eof word arriving mid-frame can only carry one report, the abort of the old frame
  always_comb begin
    w_report     = 1'b0;
    w_rep_good   = 1'b0;
    w_rep_status = ST_OK;
    if (d_valid) begin
      case (r_state)
        S_IDLE, S_DROP: begin
          if (sof && eof) begin
            w_report     = 1'b1;
            w_rep_status = ST_SHORT;
          end
        end
        S_PAYLOAD: begin
          if (sof) begin
            w_report     = 1'b1;
            w_rep_status = ST_LONG;
          end else if (eof) begin
            w_report = 1'b1;
            if (w_wcnt_inc < WC_W'(3)) begin
              w_rep_status = ST_SHORT;
            end else if (w_crc_ok) begin
              w_rep_good   = 1'b1;
              w_rep_status = ST_OK;
            end else begin
              w_rep_status = ST_CRC_ERR;
            end
          end else if (w_wcnt_inc == WC_W'(MAX_WORDS)) begin
            w_report     = 1'b1;
            w_rep_status = ST_LONG;
          end
        end
        default: ;
      endcase
    end
  end

  // Delay line and CRC accumulation; a word enters the CRC only after two newer words have arrived
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_crc  <= CRC_INIT;
      r_d1   <= '0;
      r_d2   <= '0;
      r_fill <= '0;
      r_wcnt <= '0;
    end else if (w_start) begin
      r_crc  <= CRC_INIT;
      r_d1   <= d;
      r_d2   <= '0;
      r_fill <= 2'd1;
      r_wcnt <= WC_W'(1);
    end else if (w_shift) begin
      if (r_fill == 2'd2) r_crc <= w_crc_step;
      else                r_fill <= r_fill + 2'd1;
      r_d2   <= r_d1;
      r_d1   <= d;
      r_wcnt <= w_wcnt_inc;
    end
  end

  // Registered verdict and saturating counters, all updated together so counters agree with done
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_done      <= 1'b0;
      r_good      <= 1'b0;
      r_status    <= ST_OK;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_done <= w_report;
      if (w_report) begin
        r_good   <= w_rep_good;
        r_status <= w_rep_status;
        if (r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        if ((w_rep_status != ST_OK) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign done      = r_done;
  assign good      = r_good;
  assign status    = r_status;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Directed bench for crc32_frame_checker with a small MAX_WORDS and narrow counters.
// The CRC reference below runs the non-reflected MSB-first form of the polynomial.
module tb_crc32_frame_checker;

  localparam int MAXW = 16;
  localparam int CW   = 5;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   d;
  logic          d_valid;
  logic          sof;
  logic          eof;
  logic          done;
  logic          good;
  logic [1:0]    status;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] err_cnt;

  int errorCount = 0;
  int checkCount = 0;
  logic [CW-1:0] expFrames = '0;
  logic [CW-1:0] expErrs   = '0;

  logic [15:0] frm[$];
  int          doneIdx[$];
  logic        doneGood[$];
  logic [1:0]  doneStat[$];

  crc32_frame_checker #(.MAX_WORDS(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .sof(sof), .eof(eof),
    .done(done), .good(good), .status(status), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Normal-form CRC state over the first n words of frm; transmitted A = ~N[15:0], B = ~N[31:16]
  function automatic logic [31:0] model_state(input int n);
    logic [31:0] s;
    logic        fb;
    s = 32'hFFFF_FFFF;
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 16; b++) begin
        fb = s[31] ^ frm[w][b];
        s  = {s[30:0], 1'b0};
        if (fb) s = s ^ 32'h04C1_1DB7;
      end
    end
    return s;
  endfunction

  task automatic build_frame(input int npay, input logic [15:0] base);
    logic [31:0] s;
    frm.delete();
    for (int i = 0; i < npay; i++) frm.push_back(base + 16'(i));
    s = model_state(npay);
    frm.push_back(~s[15:0]);
    frm.push_back(~s[31:16]);
  endtask

  task automatic expect_report(input logic [1:0] st);
    if (expFrames != CNT_MAX) expFrames = expFrames + 1'b1;
    if (st != 2'd0 && expErrs != CNT_MAX) expErrs = expErrs + 1'b1;
  endtask

  task automatic send_word(input logic [15:0] w, input logic s, input logic e,
                           output logic dn, output logic g, output logic [1:0] st);
    d = w; sof = s; eof = e; d_valid = 1'b1;
    @(posedge clk); #1;
    dn = done; g = good; st = status;
    d_valid = 1'b0; sof = 1'b0; eof = 1'b0;
  endtask

  task automatic idle(input int n, output int nDone);
    nDone = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (done) nDone++;
    end
  endtask

  task automatic send_frame(input int gap);
    logic dn, g;
    logic [1:0] st;
    int nd;
    int last;
    last = frm.size() - 1;
    doneIdx.delete(); doneGood.delete(); doneStat.delete();
    for (int i = 0; i <= last; i++) begin
      send_word(frm[i], i == 0, i == last, dn, g, st);
      if (dn) begin
        doneIdx.push_back(i); doneGood.push_back(g); doneStat.push_back(st);
      end
      if (i != last && gap > 0) begin
        idle(gap, nd);
        if (nd != 0) begin
          doneIdx.push_back(-1); doneGood.push_back(1'b0); doneStat.push_back(2'd0);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; d = '0; d_valid = 1'b0; sof = 1'b0; eof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if ({done, good, status} !== 4'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_flags: got done=%0b good=%0b status=%0d, want 0 0 0", done, good, status);
    end
    checkCount++;
    if (frame_cnt !== '0 || err_cnt !== '0) begin
      errorCount++;
      $display("[TB] FAIL reset_counters: got frame=%0d err=%0d, want 0 0", frame_cnt, err_cnt);
    end
    reset = 1'b1;
  endtask

  task automatic test_good_frame();
    int nd;
    build_frame(8, 16'h0001);
    send_frame(0);
    expect_report(2'd0);
    checkCount++;
    if (doneIdx.size() != 1 || doneIdx[0] != 9 || doneGood[0] !== 1'b1 || doneStat[0] !== 2'd0) begin
      errorCount++;
      $display("[TB] FAIL good_frame: got dones=%0d good=%0b status=%0d, want 1 done at word 10 good=1 status=0",
               doneIdx.size(), good, status);
    end
    checkCount++;
    if (frame_cnt !== 5'd1 || err_cnt !== 5'd0) begin
      errorCount++;
      $display("[TB] FAIL good_counters: got frame=%0d err=%0d, want 1 0", frame_cnt, err_cnt);
    end
    idle(1, nd);
    checkCount++;
    if (nd != 0 || good !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL done_pulse: got extra dones=%0d good=%0b, want 0 and good held at 1", nd, good);
    end
  endtask

  task automatic test_crc_error();
    build_frame(8, 16'h0001);
    frm[3] = frm[3] ^ 16'h0001;
    send_frame(0);
    expect_report(2'd1);
    checkCount++;
    if (doneIdx.size() != 1 || doneGood[0] !== 1'b0 || doneStat[0] !== 2'd1 || err_cnt !== expErrs) begin
      errorCount++;
      $display("[TB] FAIL crc_err_payload: got dones=%0d good=%0b status=%0d err=%0d, want 1 0 1 %0d",
               doneIdx.size(), good, status, err_cnt, expErrs);
    end
    build_frame(8, 16'h0001);
    frm[9] = frm[9] ^ 16'h0001;
    send_frame(0);
    expect_report(2'd1);
    checkCount++;
    if (doneIdx.size() != 1 || doneGood[0] !== 1'b0 || doneStat[0] !== 2'd1 || err_cnt !== expErrs) begin
      errorCount++;
      $display("[TB] FAIL crc_err_wordB: got dones=%0d good=%0b status=%0d err=%0d, want 1 0 1 %0d",
               doneIdx.size(), good, status, err_cnt, expErrs);
    end
  endtask

  task automatic test_short();
    logic dn, g;
    logic [1:0] st;
    frm.delete();
    frm.push_back(16'h1111);
    frm.push_back(16'h2222);
    send_frame(0);
    expect_report(2'd2);
    checkCount++;
    if (doneIdx.size() != 1 || doneIdx[0] != 1 || doneStat[0] !== 2'd2) begin
      errorCount++;
      $display("[TB] FAIL short_two_word: got dones=%0d status=%0d, want 1 done status=2", doneIdx.size(), status);
    end
    send_word(16'h3333, 1'b1, 1'b1, dn, g, st);
    expect_report(2'd2);
    checkCount++;
    if (dn !== 1'b1 || st !== 2'd2 || g !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL short_one_word: got done=%0b status=%0d good=%0b, want 1 2 0", dn, st, g);
    end
    checkCount++;
    if (err_cnt !== expErrs || frame_cnt !== expFrames) begin
      errorCount++;
      $display("[TB] FAIL short_counters: got frame=%0d err=%0d, want %0d %0d", frame_cnt, err_cnt, expFrames, expErrs);
    end
  endtask

  task automatic test_long();
    int nd;
    frm.delete();
    for (int i = 0; i < 20; i++) frm.push_back(16'h0100 + 16'(i));
    send_frame(0);
    expect_report(2'd3);
    idle(3, nd);
    checkCount++;
    if (doneIdx.size() != 1 || doneIdx[0] != 15 || doneStat[0] !== 2'd3 || nd != 0) begin
      errorCount++;
      $display("[TB] FAIL long_frame: got dones=%0d first_at=%0d status=%0d later=%0d, want 1 at word 16 status=3 later=0",
               doneIdx.size(), (doneIdx.size() > 0) ? doneIdx[0] + 1 : -1, status, nd);
    end
    build_frame(8, 16'h0040);
    send_frame(0);
    expect_report(2'd0);
    checkCount++;
    if (doneIdx.size() != 1 || doneGood[0] !== 1'b1 || doneStat[0] !== 2'd0) begin
      errorCount++;
      $display("[TB] FAIL after_long: got dones=%0d good=%0b status=%0d, want 1 1 0", doneIdx.size(), good, status);
    end
  endtask

  task automatic test_abort();
    logic dn, g;
    logic [1:0] st;
    int nd;
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      send_word(16'h0A00 + 16'(i), i == 0, 1'b0, dn, g, st);
      if (dn) nd++;
    end
    build_frame(4, 16'h0500);
    send_frame(0);
    expect_report(2'd3);
    expect_report(2'd0);
    checkCount++;
    if (nd != 0 || doneIdx.size() != 2 || doneIdx[0] != 0 || doneStat[0] !== 2'd3) begin
      errorCount++;
      $display("[TB] FAIL abort_report: got early=%0d dones=%0d status0=%0d, want 0 2 3",
               nd, doneIdx.size(), (doneStat.size() > 0) ? doneStat[0] : 2'd0);
    end
    checkCount++;
    if (doneIdx.size() != 2 || doneIdx[1] != 5 || doneGood[1] !== 1'b1 || doneStat[1] !== 2'd0) begin
      errorCount++;
      $display("[TB] FAIL abort_restart: got dones=%0d good=%0b status=%0d, want second done at word 6 good=1 status=0",
               doneIdx.size(), good, status);
    end
    checkCount++;
    if (frame_cnt !== expFrames || err_cnt !== expErrs) begin
      errorCount++;
      $display("[TB] FAIL abort_counters: got frame=%0d err=%0d, want %0d %0d", frame_cnt, err_cnt, expFrames, expErrs);
    end
  endtask

  task automatic test_gaps();
    build_frame(8, 16'h0077);
    send_frame(3);
    expect_report(2'd0);
    checkCount++;
    if (doneIdx.size() != 1 || doneIdx[0] != 9 || doneGood[0] !== 1'b1 || doneStat[0] !== 2'd0) begin
      errorCount++;
      $display("[TB] FAIL gapped_frame: got dones=%0d good=%0b status=%0d, want 1 done good=1 status=0",
               doneIdx.size(), good, status);
    end
  endtask

  task automatic test_reset_midframe();
    logic dn, g;
    logic [1:0] st;
    int nd;
    build_frame(8, 16'h0090);
    for (int i = 0; i < 3; i++) send_word(frm[i], i == 0, 1'b0, dn, g, st);
    reset = 1'b0;
    send_word(frm[3], 1'b0, 1'b0, dn, g, st);
    reset = 1'b1;
    expFrames = '0;
    expErrs   = '0;
    checkCount++;
    if ({done, good, status} !== 4'b0 || frame_cnt !== '0 || err_cnt !== '0) begin
      errorCount++;
      $display("[TB] FAIL midframe_reset: got done=%0b good=%0b status=%0d frame=%0d err=%0d, want all 0",
               done, good, status, frame_cnt, err_cnt);
    end
    nd = 0;
    for (int i = 4; i < 10; i++) begin
      send_word(frm[i], 1'b0, i == 9, dn, g, st);
      if (dn) nd++;
    end
    checkCount++;
    if (nd != 0 || frame_cnt !== '0) begin
      errorCount++;
      $display("[TB] FAIL midframe_no_report: got dones=%0d frame=%0d, want 0 0", nd, frame_cnt);
    end
  endtask

  task automatic test_saturation();
    logic dn, g;
    logic [1:0] st;
    for (int i = 0; i < 30; i++) begin
      send_word(16'hBEEF, 1'b1, 1'b1, dn, g, st);
      expect_report(2'd2);
    end
    checkCount++;
    if (err_cnt !== 5'd30 || frame_cnt !== 5'd30) begin
      errorCount++;
      $display("[TB] FAIL sat_preload: got frame=%0d err=%0d, want 30 30", frame_cnt, err_cnt);
    end
    for (int f = 0; f < 3; f++) begin
      build_frame(8, 16'h0001);
      frm[3] = frm[3] ^ 16'h0001;
      send_frame(0);
      expect_report(2'd1);
      checkCount++;
      if (doneStat.size() != 1 || doneStat[0] !== 2'd1 || err_cnt !== expErrs || frame_cnt !== expFrames) begin
        errorCount++;
        $display("[TB] FAIL sat_frame%0d: got status=%0d frame=%0d err=%0d, want 1 %0d %0d",
                 f, status, frame_cnt, err_cnt, expFrames, expErrs);
      end
    end
    checkCount++;
    if (err_cnt !== 5'h1F) begin
      errorCount++;
      $display("[TB] FAIL sat_hold: got err=%0d, want 31", err_cnt);
    end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_short();
    test_long();
    test_abort();
    test_gaps();
    test_reset_midframe();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/crc32_frame_checker.md
Name: crc32_frame_checker

Overview:
- Receive-side counterpart of the 16-bit-datapath CRC-32 generator in the DMB link.
- Consumes a framed 16-bit word stream in which the last two words of each frame are the CRC appended by the generator.
- Recomputes the CRC over the payload, compares it against the received CRC words, and reports a per-frame status.
- Maintains saturating frame and error counters for slow-control readout.

Parameters:
MAX_WORDS, 4096, maximum frame length in words, CRC words included; longer frames are flagged LONG.
CNT_W, 16, width of the frame and error counters.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
d  input  16  received data word
d_valid  input  1  d/sof/eof qualifier; sof and eof are ignored when low
sof  input  1  first word of frame
eof  input  1  last word of frame (second CRC word)
done  output  1  one-cycle pulse: frame verdict valid
good  output  1  frame passed; valid with done
status  output  2  0=OK, 1=CRC_ERR, 2=SHORT, 3=LONG_OR_ABORT; valid with done
frame_cnt  output  CNT_W  frames completed, saturating
err_cnt  output  CNT_W  frames with status!=0, saturating

Behaviour:
- CRC algorithm is identical to the generator.
  - Polynomial 0x04C11DB7, reflected-bit 16-bit parallel step, init 0xFFFFFFFF.
  - Applied to each payload word.
- Transmitted CRC words for final register C:
  - Word A = ~bitrev16(C[31:16]), then word B = ~bitrev16(C[15:0]).
  - Frame passes iff received A and B match.
- The frame length is unknown until eof, so the datapath uses a 2-word delay line (d1 = newest, d2 = older) plus a fill count 0..2.
  - On each valid non-sof word with fill==2: crc_reg <= step(crc_reg, d2).
  - The delay line shifts on every valid word.
- On a valid eof word (state PAYLOAD, total words >= 3):
  - C = step(crc_reg, d2), computed combinationally.
  - good = (d1 == ~bitrev16(C[31:16])) && (d == ~bitrev16(C[15:0])).
- States and transitions:
  - IDLE: await valid sof. Then load crc_reg=0xFFFFFFFF, d1=d, fill=1, word count=1, go to PAYLOAD. If the sof word also has eof, report SHORT and stay in IDLE.
  - PAYLOAD: accumulate as above.
    - eof with word count (this word included) < 3 -> SHORT.
    - eof otherwise -> OK or CRC_ERR.
    - Word count reaching MAX_WORDS without eof -> report LONG_OR_ABORT immediately, go to DROP.
    - Valid sof while in PAYLOAD: report LONG_OR_ABORT for the old frame, and restart a new frame on that same word.
  - DROP: discard words until a valid eof (return to IDLE, no second report) or a valid sof (start a new frame, as in IDLE).
- Valid words in IDLE without sof are ignored; no report.
- Latency: done/good/status are registered and asserted in the cycle after the word that ends the frame.
  - done is high for exactly one cycle per frame.
  - good/status hold their values until the next done.
- Counters:
  - frame_cnt increments on every done; err_cnt increments on done with status!=0.
  - Both saturate at all-ones and do not wrap.
- d_valid low: no state, CRC, or delay-line change (gaps inside a frame are legal).
- Reset (reset==0 at a clock edge), including mid-frame:
  - State IDLE, crc_reg=0xFFFFFFFF, fill=0, done=0, good=0, status=0, frame_cnt=0, err_cnt=0.
  - No report for the interrupted frame.

Decomposition:
- Shared package dmb_crc_pkg holds:
  - function crc32_d16_step(crc[31:0], d[15:0]) returning [31:0], the exact generator XOR equations;
  - function bitrev16;
  - CRC_INIT=32'hFFFFFFFF;
  - status localparams ST_OK, ST_CRC_ERR, ST_SHORT, ST_LONG.
- The generator refactors onto the same package so both ends share one equation set.
- No sub-module; a single module with a 3-state FSM.

Test Plan:
- 8-word payload 0x0001..0x0008, followed by words A/B from the package model (same as the generator output), sof on word 1, eof on word 10 -> one cycle later done=1, good=1, status=0, frame_cnt=1, err_cnt=0.
- Same frame with bit 0 of payload word 4 flipped -> done=1, good=0, status=1, err_cnt=1. Repeat with word B flipped instead -> status=1.
- 2-word frame (sof on word 1, eof on word 2), and separately a single word with sof and eof together -> status=2 each time; err_cnt increments by 2.
- MAX_WORDS=16, 20-word frame -> done with status=3 the cycle after word 16; no second done at eof; the next good frame reports status=0.
- Valid sof at word 5 of a frame, followed by a complete good 6-word frame -> done status=3 for the aborted frame, then done good=1 for the new frame.
- Good frame with d_valid low for 3 cycles between every word -> good=1. Assert reset low mid-frame -> all outputs and counters 0 and no done; force err_cnt to 0xFFFE, then send 3 bad frames -> err_cnt holds at 0xFFFF.
